// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler: FSM state
// encoding, default sizes and the round-robin grant search.
package mult_sched_pkg;

  typedef enum logic [1:0] {IDLE, APPX, EXACT, RESP} state_e;

  localparam int DEF_W    = 32;
  localparam int DEF_NREQ = 4;
  localparam int MAX_NREQ = 16;

  // First valid index at or above ptr, wrapping modulo nreq. Searching k
  // downward lets the smallest distance from ptr win.
  function automatic logic [3:0] rr_grant(input logic [MAX_NREQ-1:0] vld,
                                          input logic [3:0] ptr,
                                          input int nreq);
    logic [3:0] g;
    int j;
    g = ptr;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % nreq;
      if (k < nreq && vld[j[3:0]]) g = j[3:0];
    end
    return g;
  endfunction

endpackage

// File: rtl/appx_mult_core.sv
// Single-cycle approximate multiplier: zero short-circuit, identity for b==1,
// otherwise a doubled.
module appx_mult_core #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (a_i == '0 || b_i == '0) y_o = '0;
    else if (b_i == W'(1))      y_o = {{W{1'b0}}, a_i};
    else                        y_o = {{(W-1){1'b0}}, a_i, 1'b0};
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one multiply resource among NREQ requesters,
// with an approximate single-cycle path and an exact radix-2 shift-add path.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  input  logic [NREQ-1:0]           req_appx,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*W-1:0]            rsp_y,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(W);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   gnt;
  logic [2*W-1:0]   y_q, y_d;
  logic [2*W-1:0]   mc_q, mc_d;
  logic [W-1:0]     b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   appx_y;
  logic [W-1:0]     a_arr [NREQ];
  logic [W-1:0]     b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  assign gnt = IDW'(rr_grant(16'(req_valid), 4'(rr_ptr_q), NREQ));

  // mc_q still holds the unshifted operand a while in APPX.
  appx_mult_core #(.W(W)) u_appx (
    .a_i (mc_q[W-1:0]),
    .b_i (b_q),
    .y_o (appx_y)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    y_d       = y_q;
    mc_d      = mc_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[gnt] = !rst;
          id_d  = gnt;
          mc_d  = {{W{1'b0}}, a_arr[gnt]};
          b_d   = b_arr[gnt];
          y_d   = '0;
          cnt_d = '0;
          if (a_arr[gnt] == '0 || b_arr[gnt] == '0) state_d = RESP;
          else if (req_appx[gnt])                    state_d = APPX;
          else                                       state_d = EXACT;
        end
      end
      APPX: begin
        y_d     = appx_y;
        state_d = RESP;
      end
      EXACT: begin
        // One multiplier bit per cycle, LSB first; multiplicand shifts up.
        if (b_q[0]) y_d = y_q + mc_q;
        mc_d  = mc_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      y_q      <= '0;
      mc_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      y_q      <= y_d;
      mc_q     <= mc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: directed vector table, round-robin, backpressure
// and mid-operation reset sequences, then randomized traffic against a model.
module tb_mult_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_appx;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_id;
  logic [2*W-1:0]    rsp_y;

  int n_pass = 0;
  int n_tot  = 0;

  mult_share_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_appx  (req_appx),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        appx;
    logic [63:0] ey;
    int          elat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Reference: product defined by the mode rules, latency by the path taken.
  function automatic logic [63:0] model_y(input logic [31:0] a, input logic [31:0] b,
                                          input logic appx);
    if (a == 0 || b == 0) return 64'd0;
    if (!appx) return 64'(a) * 64'(b);
    if (b == 1) return 64'(a);
    return 64'(a) * 64'd2;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic appx);
    if (a == 0 || b == 0) return 1;
    return appx ? 2 : W + 1;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {63'd0, busy}, 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic appx, input logic [63:0] ey, input int elat,
                        input int stall, input string nm);
    int lat;
    wait_idle();
    @(negedge clk);
    rsp_ready = (stall == 0);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_appx[idx] = appx;
    #1;
    chk({nm, "_ready"}, 64'(req_ready), 64'(4'b0001 << idx));
    @(posedge clk);
    #1;
    req_valid = '0;
    req_a[idx*W +: W] = $urandom;
    req_b[idx*W +: W] = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 100);
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_y"}, rsp_y, ey);
    chk({nm, "_id"}, 64'(rsp_id), 64'(idx));
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk({nm, "_hold_y"}, rsp_y, ey);
      chk({nm, "_hold_v"}, 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ng, nr, cyc, last_g, gid, k;
    logic saw;
    logic [31:0] ra, rb;
    logic rm;
    int ri, rs;

    vecs[0] = '{0, 32'd7,          32'd1,          1'b1, 64'd7,                 2};
    vecs[1] = '{0, 32'd7,          32'd5,          1'b1, 64'd14,                2};
    vecs[2] = '{0, 32'h8000_0001,  32'd9,          1'b1, 64'h1_0000_0002,       2};
    vecs[3] = '{2, 32'd7,          32'd5,          1'b0, 64'd35,                W + 1};
    vecs[4] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, W + 1};
    vecs[5] = '{3, 32'd0,          32'd123,        1'b0, 64'd0,                 1};
    vecs[6] = '{0, 32'd0,          32'd123,        1'b1, 64'd0,                 1};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_appx = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 4'hF;
    req_a = {4{32'd3}};
    req_b = {4{32'd3}};
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_y", rsp_y, 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_txn(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].appx, vecs[i].ey, vecs[i].elat,
             0, $sformatf("vec%0d", i));
    wait_idle();

    // Round-robin with every requester continuously valid.
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 32'(i + 1);
      req_b[i*W +: W] = 32'd3;
      req_appx[i] = 1'b1;
    end
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    ng = 0; nr = 0; cyc = 0; last_g = -10;
    while (ng < 6 && cyc < 60) begin
      #1;
      if (req_ready != 0) begin
        gid = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        chk("rr_onehot", 64'($onehot(req_ready)), 64'd1);
        chk("rr_order", 64'(gid), 64'(ng % NREQ));
        if (ng > 0) chk("rr_gap", 64'(cyc - last_g), 64'd3);
        last_g = cyc;
        ng++;
      end
      if (rsp_valid) begin
        chk("rr_rsp_id", 64'(rsp_id), 64'(nr % NREQ));
        chk("rr_rsp_y", rsp_y, model_y(32'(nr % NREQ + 1), 32'd3, 1'b1));
        nr++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    chk("rr_grants", 64'(ng), 64'd6);
    wait_idle();

    // Backpressure in RESP while other requesters wait.
    reset_dut();
    req_a[1*W +: W] = 32'd5;
    req_b[1*W +: W] = 32'd7;
    req_appx[1] = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("bp_ready", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1;
    req_valid = 4'b1101;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      chk("bp_noready", 64'(req_ready), 64'd0);
    end while (!rsp_valid && k < 10);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_y", rsp_y, 64'd10);
      chk("bp_id", 64'(rsp_id), 64'd1);
      chk("bp_noready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_next_grant", 64'(req_ready), 64'b0100);
    req_valid = '0;
    wait_idle();

    // Reset in the middle of an exact operation.
    @(negedge clk);
    req_a[3*W +: W] = 32'd9;
    req_b[3*W +: W] = 32'd9;
    req_appx[3] = 1'b0;
    req_valid = 4'b1000;
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_valid", 64'(rsp_valid), 64'd0);
    chk("abort_y", rsp_y, 64'd0);
    chk("abort_id", 64'(rsp_id), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw |= rsp_valid;
    end
    chk("abort_no_rsp", 64'(saw), 64'd0);
    req_a[0*W +: W] = 32'd4;
    req_b[0*W +: W] = 32'd4;
    req_appx[0] = 1'b1;
    req_valid = 4'b1001;
    #1;
    chk("abort_regrant", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    // Randomized traffic against the reference model.
    for (int t = 0; t < 30; t++) begin
      ri = $urandom_range(0, NREQ - 1);
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       ra = 32'd0;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        default: rb = $urandom;
      endcase
      rs = $urandom_range(0, 2);
      do_txn(ri, ra, rb, rm, model_y(ra, rb, rm), model_lat(ra, rb, rm), rs,
             $sformatf("rnd%0d", t));
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
